// File: rtl/pavana_xbar_pkg.sv
// Shared definitions for the pavana_xbar slave-side models: command encodings,
// the LFSR feedback polynomial and small helper functions.
package pavana_xbar_pkg;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

    // Galois right-shift taps for x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {1'b0, state[15:1]} ^ (state[0] ? LFSR_POLY : 16'h0000);
    endfunction

    function automatic logic [31:0] mem_pattern(input logic [31:0] slave_id,
                                                input logic [31:0] word_idx);
        return (slave_id << 30) + (word_idx << 2);
    endfunction

endpackage

// File: rtl/pavana_lfsr16.sv
// 16-bit Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module pavana_lfsr16
    import pavana_xbar_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_seed,
    output logic [15:0] o_state
);

    logic [15:0] r_state;

    // State register: reload on reset, advance when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
        end else if (i_en) begin
            r_state <= lfsr_next(r_state);
        end else begin
            r_state <= r_state;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/slave_mem_ooo_model.sv
// Slave memory model with buffered, pseudo-randomly delayed read responses.
// Define SLAVE_MEM_OOO_EN for out-of-order issue; default issues in accept order.
module slave_mem_ooo_model
    import pavana_xbar_pkg::*;
#(
    parameter int MEMSIZE32 = 1024,
    parameter int BUFSIZE   = 4,
    parameter int TID_WIDTH = 2,
    parameter int MIN_LAT   = 1,
    parameter int MAX_LAT   = 8,
    parameter int SLAVE_ID  = 0,
    parameter int RAND_SEED = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 slave_req,
    input  logic [31:0]          slave_addr,
    input  logic                 slave_cmd,
    input  logic [TID_WIDTH-1:0] slave_reqtid,
    input  logic [31:0]          slave_wdata,
    output logic                 slave_ack,
    output logic [TID_WIDTH-1:0] slave_resptid,
    output logic [31:0]          slave_rdata,
    output logic                 slave_resp
);

    localparam int AW       = $clog2(MEMSIZE32);
    localparam int IW       = (BUFSIZE > 1) ? $clog2(BUFSIZE) : 1;
    localparam int CW       = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;
    localparam int LAT_SPAN = MAX_LAT - MIN_LAT + 1;

    if (MAX_LAT < MIN_LAT) begin : g_bad_lat
        $fatal(1, "slave_mem_ooo_model: MAX_LAT < MIN_LAT");
    end
    if (BUFSIZE < 1 || BUFSIZE > 16) begin : g_bad_buf
        $fatal(1, "slave_mem_ooo_model: BUFSIZE must be 1..16");
    end
    if ((MEMSIZE32 & (MEMSIZE32 - 1)) != 0) begin : g_bad_mem
        $fatal(1, "slave_mem_ooo_model: MEMSIZE32 must be a power of two");
    end

    typedef struct packed {
        logic                 valid;
        logic [TID_WIDTH-1:0] tid;
        logic [31:0]          rdata;
        logic [CW-1:0]        cnt;
    } rd_entry_t;

    rd_entry_t     r_buf [BUFSIZE];
    // Stored as XOR against the power-on pattern so a zero power-up state reads back as that pattern.
    logic [31:0]   r_delta [MEMSIZE32];
    logic          r_resp;
    logic [TID_WIDTH-1:0] r_resptid;
    logic [31:0]   r_rdata;

    logic [15:0]   w_lfsr;
    logic [AW-1:0] w_widx;
    logic [31:0]   w_pattern;
    logic [31:0]   w_mem_rd;
    logic [CW-1:0] w_lat;
    logic          w_has_free;
    logic [IW-1:0] w_alloc_idx;
    logic          w_sel_ok;
    logic [IW-1:0] w_sel_idx;
    logic          w_acc_rd;
    logic          w_acc_wr;
    logic          w_unused_addr;

    pavana_lfsr16 u_lfsr (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_en    (1'b1),
        .i_seed  (16'(RAND_SEED)),
        .o_state (w_lfsr)
    );

    assign w_widx        = slave_addr[AW+1:2];
    assign w_unused_addr = ^{slave_addr[31:AW+2], slave_addr[1:0]};
    assign w_pattern     = mem_pattern(32'(SLAVE_ID), 32'(w_widx));
    assign w_mem_rd      = r_delta[w_widx] ^ w_pattern;
    assign w_lat         = CW'(MIN_LAT + (w_lfsr % LAT_SPAN));

    // Lowest-index free entry; the descending scan lets lower indices win.
    always_comb begin
        w_has_free  = 1'b0;
        w_alloc_idx = IW'(0);
        for (int i = BUFSIZE - 1; i >= 0; i--) begin
            w_has_free  = w_has_free | !r_buf[i].valid;
            w_alloc_idx = !r_buf[i].valid ? IW'(i) : w_alloc_idx;
        end
    end

    assign slave_ack = !rst_i && ((slave_cmd == CMD_WR) || w_has_free);
    assign w_acc_rd  = slave_req && slave_ack && (slave_cmd == CMD_RD);
    assign w_acc_wr  = slave_req && slave_ack && (slave_cmd == CMD_WR);

`ifdef SLAVE_MEM_OOO_EN
    logic [IW-1:0] w_start;
    int            w_scan;

    assign w_start = IW'(w_lfsr % BUFSIZE);

    // First ready entry scanning upward from a random start, with wrap.
    always_comb begin
        w_sel_ok  = 1'b0;
        w_sel_idx = IW'(0);
        w_scan    = 0;
        for (int i = BUFSIZE - 1; i >= 0; i--) begin
            w_scan = (int'(w_start) + i) % BUFSIZE;
            w_sel_idx = (r_buf[w_scan].valid && (r_buf[w_scan].cnt == CW'(0)))
                        ? IW'(w_scan) : w_sel_idx;
            w_sel_ok  = w_sel_ok | (r_buf[w_scan].valid && (r_buf[w_scan].cnt == CW'(0)));
        end
    end
`else
    logic [IW-1:0] r_age [BUFSIZE];
    logic [IW-1:0] r_age_head;
    logic [IW-1:0] r_age_tail;

    function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
        return (p == IW'(BUFSIZE - 1)) ? IW'(0) : p + IW'(1);
    endfunction

    // Every valid entry sits in the age FIFO, so an empty FIFO never sees a valid head.
    assign w_sel_idx = r_age[r_age_head];
    assign w_sel_ok  = r_buf[w_sel_idx].valid && (r_buf[w_sel_idx].cnt == CW'(0));

    // Age FIFO of entry indices in acceptance order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_age_head <= IW'(0);
            r_age_tail <= IW'(0);
        end else begin
            if (w_acc_rd) begin
                r_age[r_age_tail] <= w_alloc_idx;
                r_age_tail        <= ptr_inc(r_age_tail);
            end
            if (w_sel_ok) begin
                r_age_head <= ptr_inc(r_age_head);
            end
        end
    end
`endif

    // Read buffer countdown, allocation and response issue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BUFSIZE; i++) begin
                r_buf[i] <= '0;
            end
            r_resp    <= 1'b0;
            r_resptid <= {TID_WIDTH{1'b0}};
            r_rdata   <= 32'h0000_0000;
        end else begin
            for (int i = 0; i < BUFSIZE; i++) begin
                if (r_buf[i].valid && (r_buf[i].cnt != CW'(0))) begin
                    r_buf[i].cnt <= r_buf[i].cnt - CW'(1);
                end
            end
            if (w_sel_ok) begin
                r_buf[w_sel_idx].valid <= 1'b0;
                r_resp    <= 1'b1;
                r_resptid <= r_buf[w_sel_idx].tid;
                r_rdata   <= r_buf[w_sel_idx].rdata;
            end else begin
                r_resp    <= 1'b0;
            end
            if (w_acc_rd) begin
                r_buf[w_alloc_idx] <= '{valid: 1'b1, tid: slave_reqtid,
                                        rdata: w_mem_rd, cnt: w_lat};
            end
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (w_acc_wr) begin
            r_delta[w_widx] <= slave_wdata ^ w_pattern;
        end
    end

    assign slave_resp    = r_resp;
    assign slave_resptid = r_resptid;
    assign slave_rdata   = r_rdata;

endmodule
